// File: rtl/framebuffer_writer_pkg.sv
// Shared types for the framebuffer writer: screen coordinate struct,
// default screen geometry and the writer FSM state encoding.
package framebuffer_writer_pkg;

  // Coordinate field width; wide enough for the default screen plus off-screen inputs.
  localparam int unsigned XY_W = 10;

  localparam int unsigned DEF_SCREEN_W = 640;
  localparam int unsigned DEF_SCREEN_H = 480;

  typedef struct packed {
    logic [XY_W-1:0] x;
    logic [XY_W-1:0] y;
  } screen_xy_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fbw_state_t;

  // A rectangle with an inverted axis covers no pixels.
  function automatic logic is_degenerate(input screen_xy_t p0, input screen_xy_t p1);
    return (p1.x < p0.x) || (p1.y < p0.y);
  endfunction

endpackage

// File: rtl/framebuffer_writer.sv
// Rectangle-fill writer: accepts one fill command at a time and streams
// one pixel write per accepted framebuffer handshake in raster order.
// Optional clipping to the visible screen is enabled by FB_WRITER_CLIP_EN.
module framebuffer_writer
  import framebuffer_writer_pkg::*;
#(
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  screen_xy_t cmd_p0,
  input  screen_xy_t cmd_p1,
  input  logic [2:0] cmd_color,
  output logic       wr_en,
  input  logic       wr_ready,
  output screen_xy_t wr_coords,
  output logic [2:0] wr_color,
  output logic       done
);

  localparam logic [XY_W-1:0] MAX_X = XY_W'(SCREEN_W - 1);
  localparam logic [XY_W-1:0] MAX_Y = XY_W'(SCREEN_H - 1);

  fbw_state_t      state_q, state_d;
  logic [XY_W-1:0] p0_x_q, p0_x_d;
  screen_xy_t      p1_q, p1_d;
  screen_xy_t      wr_coords_d;
  logic [2:0]      wr_color_d;
  logic            done_d;

  screen_xy_t      acc_p1;
  logic            acc_degen;

`ifdef FB_WRITER_CLIP_EN
  // Clamp the far corner on-screen; an off-screen near corner draws nothing.
  always_comb begin
    acc_p1.x  = (cmd_p1.x > MAX_X) ? MAX_X : cmd_p1.x;
    acc_p1.y  = (cmd_p1.y > MAX_Y) ? MAX_Y : cmd_p1.y;
    acc_degen = is_degenerate(cmd_p0, acc_p1) || (cmd_p0.x > MAX_X) || (cmd_p0.y > MAX_Y);
  end
`else
  // Coordinates pass through untouched; the source keeps them on-screen.
  always_comb begin
    acc_p1    = cmd_p1;
    acc_degen = is_degenerate(cmd_p0, cmd_p1);
  end

  logic [2*XY_W-1:0] unused_clip_bounds;
  assign unused_clip_bounds = {MAX_X, MAX_Y};
`endif

  // Next-state, address stepping and command latching.
  always_comb begin
    state_d     = state_q;
    p0_x_d      = p0_x_q;
    p1_d        = p1_q;
    wr_coords_d = wr_coords;
    wr_color_d  = wr_color;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          p0_x_d     = cmd_p0.x;
          p1_d       = acc_p1;
          wr_color_d = cmd_color;
          if (acc_degen) begin
            done_d = 1'b1;
          end else begin
            state_d     = FILL;
            wr_coords_d = cmd_p0;
          end
        end
      end
      FILL: begin
        if (wr_ready) begin
          if (wr_coords.x == p1_q.x) begin
            if (wr_coords.y == p1_q.y) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              wr_coords_d.x = p0_x_q;
              wr_coords_d.y = wr_coords.y + XY_W'(1);
            end
          end else begin
            wr_coords_d.x = wr_coords.x + XY_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      p0_x_q    <= '0;
      p1_q      <= '0;
      wr_coords <= '0;
      wr_color  <= '0;
      done      <= 1'b0;
      wr_en     <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      p0_x_q    <= p0_x_d;
      p1_q      <= p1_d;
      wr_coords <= wr_coords_d;
      wr_color  <= wr_color_d;
      done      <= done_d;
      wr_en     <= (state_d == FILL);
      cmd_ready <= (state_d == IDLE);
    end
  end

endmodule
